pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic parametrised pipeline stage register with valid/ready handshake, stall and flush.
//  Next-generation replacement for the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB):
//  payload is an opaque DATA_W vector, backpressure is native, misprediction kill is a flush input.
//  MODE selects a plain single register or a 2-entry skid buffer whose in_ready is fully registered.
// PARAMETERS
//  DATA_W  120  payload width in bits (EX/MEM bundle: pc13+inst32+rd5+result32+rs2data32+store2+load3+we1)
//  MODE    0    0 = single register (in_ready combinational from out_ready); 1 = skid buffer (registered in_ready)
// PORTS
//  CLK        in   1       clock, all state updates on rising edge
//  RST_N      in   1       asynchronous active-low reset
//  flush      in   1       kill all held entries (branch mispredict), synchronous
//  in_valid   in   1       upstream payload valid
//  in_ready   out  1       stage can accept payload this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       downstream payload valid
//  out_ready  in   1       downstream accepts payload this cycle
//  out_data   out  DATA_W  downstream payload
//  occupancy  out  2       entries held (0..1 in MODE 0, 0..2 in MODE 1)
// BEHAVIOUR
//  - Reset (RST_N low, async): out_valid=0, out_data=0, occupancy=0, skid entry empty; in_ready=1 after release.
//  - Handshake: transfer in on in_valid&&in_ready, out on out_valid&&out_ready at the rising edge;
//    in_data held only when in_valid; out_data stable while out_valid&&!out_ready.
//  - MODE 0: in_ready = !out_valid || out_ready. Accept -> out_valid=1, out_data=in_data next cycle (latency 1).
//    Drain without accept -> out_valid=0. Simultaneous drain+accept -> new payload, no bubble (full throughput).
//  - MODE 1: main slot M drives out_*, skid slot S; in_ready = !S.valid (flop output, no comb path from out_ready).
//    Accept with M empty, or M draining -> M<=in. Accept with M full and not draining -> S<=in.
//    M draining with S full -> M<=S, S cleared; no accept that cycle (in_ready=0). Order strictly FIFO.
//    Latency 1 when empty; sustained 1 item/cycle when out_ready held high.
//  - flush (priority over everything): next edge M and S invalid, occupancy=0; any input accepted in the
//    flush cycle is discarded; out handshake in the flush cycle still counts as delivered downstream.
//  - occupancy = M.valid + S.valid, registered.
//  - RST_N asserted mid-stream: all entries dropped immediately, no partial payload visible.
// CONFIGURATION
//  PIPE_ZERO_ON_FLUSH_EN: defined -> flush and drain-to-empty also clear data regs to 0
//    (out_data==0 whenever out_valid==0; matches legacy bubble-as-zero semantics, e.g. inst=0 in trace).
//  Not defined -> flush/drain clear valid bits only; data regs keep last value (fewer enables, lower power).
// STRUCTURE
//  - Package pipe_pkg: MODE_REG=0 / MODE_SKID=1 constants; em_payload_t packed struct for the EX/MEM bundle
//    and EM_PAYLOAD_W localparam so callers bind DATA_W from $bits(em_payload_t).
//  - Sub-module pipe_slot (DATA_W): one valid+data entry with load, clear and zero-on-clear option;
//    instantiated once for MODE 0, twice (M, S) for MODE 1 via generate.
// TESTING
//  1 Reset: RST_N=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, occupancy=0 same cycle; in_ready=1 after.
//  2 Stream: MODE 0/1, in_valid=1 data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency.
//  3 Stall: MODE 1, push A,B,C with out_ready=0 -> A in M, B in S, occupancy=2, in_ready=0, C held upstream;
//    release out_ready -> out A,B,C in order, no loss/duplication.
//  4 Flush: occupancy=2 plus in_valid=1 data 0x55 and flush=1 -> next cycle out_valid=0, occupancy=0, 0x55 never emitted.
//  5 Zero-on-flush: with PIPE_ZERO_ON_FLUSH_EN, after 4 out_data==0; without it out_data retains prior value, out_valid=0.
//  6 Random: both MODEs, random in_valid/out_ready/flush (5%) vs scoreboard FIFO -> order exact; MODE 1 in_ready only
//    changes at clock edges (no comb dependence on out_ready).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage buffer.
// Holds mode constants and the EX/MEM payload bundle used to size DATA_W.
package pipe_pkg;

  localparam int MODE_REG  = 0;
  localparam int MODE_SKID = 1;

  typedef struct packed {
    logic [12:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] rs2Data;
    logic [1:0]  store;
    logic [2:0]  load;
    logic        we;
  } em_payload_t;

  localparam int EM_PAYLOAD_W = $bits(em_payload_t);

endpackage

// File: rtl/pipe_slot.sv
// One valid+data storage entry with load and clear; clear wins over load.
// ZERO_ON_CLEAR also wipes the data register when the entry is cleared.
module pipe_slot #(
  parameter int DATA_W        = 8,
  parameter bit ZERO_ON_CLEAR = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] dIn,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (ZERO_ON_CLEAR) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= dIn;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush, and optional skid slot (MODE 1).
// Define PIPE_ZERO_ON_FLUSH_EN to zero the data registers whenever an entry is emptied.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 120,
  parameter int MODE   = MODE_REG
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

`ifdef PIPE_ZERO_ON_FLUSH_EN
  localparam bit ZeroOnClear = 1'b1;
`else
  localparam bit ZeroOnClear = 1'b0;
`endif

  if (MODE == MODE_REG) begin : gReg
    logic              mValid;
    logic [DATA_W-1:0] mData;
    logic              accept, drain, mLoad, mClear;

    always_comb begin
      in_ready = !mValid || out_ready;
      accept   = in_valid && in_ready;
      drain    = mValid && out_ready;
      mLoad    = accept && !flush;
      mClear   = flush || (drain && !accept);
    end

    pipe_slot #(.DATA_W(DATA_W), .ZERO_ON_CLEAR(ZeroOnClear)) uM (
      .CLK(CLK), .RST_N(RST_N), .load(mLoad), .clear(mClear),
      .dIn(in_data), .valid(mValid), .data(mData)
    );

    always_comb begin
      out_valid = mValid;
      out_data  = mData;
      occupancy = {1'b0, mValid};
    end
  end else begin : gSkid
    logic              mValid, sValid;
    logic [DATA_W-1:0] mData, sData, mIn;
    logic              accept, drain, mLoad, mClear, sLoad, sClear;

    // S only fills while M is full, so sValid implies mValid; a draining
    // M with S full refills from S and blocks input for that cycle.
    always_comb begin
      in_ready = !sValid;
      accept   = in_valid && !sValid;
      drain    = mValid && out_ready;
      mIn      = sValid ? sData : in_data;
      mLoad    = !flush && ((sValid && drain) || (accept && (!mValid || drain)));
      mClear   = flush || (drain && !sValid && !accept);
      sLoad    = !flush && accept && mValid && !drain;
      sClear   = flush || (sValid && drain);
    end

    pipe_slot #(.DATA_W(DATA_W), .ZERO_ON_CLEAR(ZeroOnClear)) uM (
      .CLK(CLK), .RST_N(RST_N), .load(mLoad), .clear(mClear),
      .dIn(mIn), .valid(mValid), .data(mData)
    );

    pipe_slot #(.DATA_W(DATA_W), .ZERO_ON_CLEAR(ZeroOnClear)) uS (
      .CLK(CLK), .RST_N(RST_N), .load(sLoad), .clear(sClear),
      .dIn(in_data), .valid(sValid), .data(sData)
    );

    always_comb begin
      out_valid = mValid;
      out_data  = mData;
      occupancy = {1'b0, mValid} + {1'b0, sValid};
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one MODE 0 and one MODE 1 instance driven independently,
// each checked against its own FIFO scoreboard plus directed reset/stall/flush steps.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int W = EM_PAYLOAD_W;
  typedef logic [W-1:0] data_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic flush [2];
  logic inValid [2];
  logic inReady [2];
  logic outValid [2];
  logic outReady [2];
  data_t inData [2];
  data_t outData [2];
  logic [1:0] occ [2];

  int checks = 0;
  int errors = 0;
  data_t sb0[$];
  data_t sb1[$];
  bit accepted [2];

  localparam data_t VA  = data_t'(120'hA0A0_0000_0000_0000_0000_0001);
  localparam data_t VB  = data_t'(120'hB0B0_0000_0000_0000_0000_0002);
  localparam data_t VC  = data_t'(120'hC0C0_0000_0000_0000_0000_0003);
  localparam data_t VX  = data_t'(120'h7070_0000_0000_0000_0000_0007);
  localparam data_t VD  = data_t'(120'hD0D0_0000_0000_0000_0000_000D);
  localparam data_t V55 = data_t'(120'h55);
  localparam data_t V66 = data_t'(120'h66);

  always #5 CLK = ~CLK;

  pipe_stage_buf #(.DATA_W(W), .MODE(MODE_REG)) uReg (
    .CLK(CLK), .RST_N(RST_N), .flush(flush[0]),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .in_data(inData[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .out_data(outData[0]),
    .occupancy(occ[0])
  );

  pipe_stage_buf #(.DATA_W(W), .MODE(MODE_SKID)) uSkid (
    .CLK(CLK), .RST_N(RST_N), .flush(flush[1]),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .in_data(inData[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .out_data(outData[1]),
    .occupancy(occ[1])
  );

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkData(input string tag, input data_t obs, input data_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic failNow(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bound expired", tag);
  endtask

  function automatic data_t rnd();
    data_t v = '0;
    for (int unsigned i = 0; i < 4; i++) v = (v << 32) | data_t'($urandom);
    return v;
  endfunction

  // One clock: model checks and scoreboard update at the falling edge, return at posedge+1.
  task automatic tick();
    data_t e;
    int sz;
    logic ir;
    @(negedge CLK);
    ir = inReady[1];
    outReady[1] = !outReady[1];
    #1;
    chkBit("skid_in_ready_comb", inReady[1], ir);
    outReady[1] = !outReady[1];
    #1;
    for (int d = 0; d < 2; d++) begin
      sz = (d == 0) ? sb0.size() : sb1.size();
      chkInt($sformatf("occupancy%0d", d), int'(occ[d]), sz);
      chkBit($sformatf("out_valid%0d", d), outValid[d], sz != 0);
      chkBit($sformatf("in_ready%0d", d), inReady[d],
             (d == 0) ? (sz == 0 || outReady[d]) : (sz < 2));
      if (outValid[d] && outReady[d]) begin
        if (sz == 0) failNow($sformatf("unexpected_output%0d", d));
        else begin
          if (d == 0) e = sb0.pop_front();
          else        e = sb1.pop_front();
          chkData($sformatf("out_data%0d", d), outData[d], e);
        end
      end
      accepted[d] = inValid[d] && inReady[d];
      if (flush[d]) begin
        if (d == 0) sb0.delete();
        else        sb1.delete();
      end else if (accepted[d]) begin
        if (d == 0) sb0.push_back(inData[d]);
        else        sb1.push_back(inData[d]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit done;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; inValid[d] = 1'b0; inData[d] = '0; outReady[d] = 1'b1; accepted[d] = 1'b0;
    end

    // Reset state
    #12;
    for (int d = 0; d < 2; d++) begin
      chkBit("rst_out_valid", outValid[d], 1'b0);
      chkData("rst_out_data", outData[d], '0);
      chkInt("rst_occupancy", int'(occ[d]), 0);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) chkBit("rst_in_ready", inReady[d], 1'b1);

    // Stream 1..8 with out_ready high: latency 1, no bubbles
    for (int k = 1; k <= 8; k++) begin
      for (int d = 0; d < 2; d++) begin inValid[d] = 1'b1; inData[d] = data_t'(k); end
      tick();
      for (int d = 0; d < 2; d++) begin
        chkBit("stream_valid", outValid[d], 1'b1);
        chkData("stream_data", outData[d], data_t'(k));
      end
    end
    for (int d = 0; d < 2; d++) inValid[d] = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) chkBit("stream_drained", outValid[d], 1'b0);

    // Stall the skid instance: A in M, B in S, C held upstream
    outReady[1] = 1'b0;
    inValid[1] = 1'b1; inData[1] = VA; tick();
    inData[1] = VB; tick();
    inData[1] = VC; tick();
    chkInt("stall_occupancy", int'(occ[1]), 2);
    chkBit("stall_in_ready", inReady[1], 1'b0);
    chkData("stall_head", outData[1], VA);
    chkBit("stall_c_held", accepted[1], 1'b0);
    outReady[1] = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (accepted[1]) inValid[1] = 1'b0;
      done = (sb1.size() == 0) && !inValid[1];
    end
    if (!done) failNow("stall_drain");

    // Flush with occupancy full and a pending input
    for (int d = 0; d < 2; d++) outReady[d] = 1'b0;
    inValid[0] = 1'b1; inData[0] = VX;
    inValid[1] = 1'b1; inData[1] = VA;
    tick();
    inValid[0] = 1'b0; inData[1] = VB;
    tick();
    chkInt("preflush_occ0", int'(occ[0]), 1);
    chkInt("preflush_occ1", int'(occ[1]), 2);
    for (int d = 0; d < 2; d++) begin inValid[d] = 1'b1; inData[d] = V55; flush[d] = 1'b1; end
    tick();
    for (int d = 0; d < 2; d++) begin inValid[d] = 1'b0; flush[d] = 1'b0; end
    for (int d = 0; d < 2; d++) begin
      chkBit("flush_valid", outValid[d], 1'b0);
      chkInt("flush_occupancy", int'(occ[d]), 0);
    end
`ifdef PIPE_ZERO_ON_FLUSH_EN
    chkData("flush_data0", outData[0], '0);
    chkData("flush_data1", outData[1], '0);
`else
    chkData("flush_data0", outData[0], VX);
    chkData("flush_data1", outData[1], VA);
`endif
    for (int d = 0; d < 2; d++) outReady[d] = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Flush on an empty stage: the accepted input is discarded
    for (int d = 0; d < 2; d++) begin inValid[d] = 1'b1; inData[d] = V66; flush[d] = 1'b1; end
    tick();
    for (int d = 0; d < 2; d++) begin
      chkBit("flush_accept", accepted[d], 1'b1);
      inValid[d] = 1'b0; flush[d] = 1'b0;
    end
    tick();
    for (int d = 0; d < 2; d++) chkBit("flush_discard", outValid[d], 1'b0);

    // Asynchronous reset mid-stream
    for (int d = 0; d < 2; d++) begin outReady[d] = 1'b0; inValid[d] = 1'b1; inData[d] = VD; end
    tick();
    for (int d = 0; d < 2; d++) begin chkBit("prerst_valid", outValid[d], 1'b1); inValid[d] = 1'b0; end
    RST_N = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chkBit("async_rst_valid", outValid[d], 1'b0);
      chkData("async_rst_data", outData[d], '0);
      chkInt("async_rst_occupancy", int'(occ[d]), 0);
    end
    sb0.delete(); sb1.delete();
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    for (int d = 0; d < 2; d++) chkBit("async_rst_in_ready", inReady[d], 1'b1);

    // Random traffic with 5% flush against the scoreboards
    for (int d = 0; d < 2; d++) accepted[d] = 1'b0;
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        if (!inValid[d] || accepted[d]) begin
          inValid[d] = $urandom_range(0, 99) < 60;
          inData[d]  = rnd();
        end
        outReady[d] = $urandom_range(0, 99) < 65;
        flush[d]    = $urandom_range(0, 99) < 5;
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin inValid[d] = 1'b0; flush[d] = 1'b0; outReady[d] = 1'b1; end
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      done = (sb0.size() == 0) && (sb1.size() == 0);
    end
    if (!done) failNow("random_drain");
    for (int d = 0; d < 2; d++) chkBit("final_empty", outValid[d], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
